// File: rtl/buffer_escrita.sv
// rtl/buffer_escrita.sv - write buffer between the nRisc datapath and the 256x8 data memory
//
// Purpose: queues CPU stores in a FIFO of {address, data} and drains them to
// memory one per cycle while the memory port is free. Loads take priority over
// draining. With BUFFER_ESCRITA_ENCAMINHAMENTO_EN defined, loads that match a
// queued store are served from the buffer (youngest match wins); without it,
// a load first waits for the buffer to empty and then reads memory.
//
// Ports:
//   clock, reset               clock, asynchronous active-low reset
//   CpuEndereco, CpuDado       load/store address and store data
//   CpuLer, CpuEscrever        load/store requests, held until accepted
//   Descarrega                 drain request, empties the buffer
//   CpuEspera                  combinational stall for the pending request
//   CpuPronto, CpuDadoLido     registered load-complete pulse and load data
//   MemEndereco, MemDadoPraEscrever, MemLerMemoria, MemEscreveMemoria,
//   MemDadoLido                data memory port (sync read, negedge write)
//   Cheio, Vazio, Ocupacao     buffer status
module buffer_escrita #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [7:0]                     CpuEndereco,
  input  logic [7:0]                     CpuDado,
  input  logic                           CpuLer,
  input  logic                           CpuEscrever,
  input  logic                           Descarrega,
  output logic                           CpuEspera,
  output logic                           CpuPronto,
  output logic [7:0]                     CpuDadoLido,
  output logic [7:0]                     MemEndereco,
  output logic [7:0]                     MemDadoPraEscrever,
  output logic                           MemLerMemoria,
  output logic                           MemEscreveMemoria,
  input  logic [7:0]                     MemDadoLido,
  output logic                           Cheio,
  output logic                           Vazio,
  output logic [$clog2(PROFUNDIDADE):0]  Ocupacao
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] N_ENTRADAS = (PW+1)'(PROFUNDIDADE);

  typedef enum logic [1:0] {OCIOSO, LEITURA, CAPTURA, DRENANDO} estado_t;

  estado_t       estado;
  logic [7:0]    fila_end  [PROFUNDIDADE];
  logic [7:0]    fila_dado [PROFUNDIDADE];
  logic [PW-1:0] cabeca;
  logic [PW-1:0] cauda;
  logic [7:0]    end_leitura;

  logic pedido;
  logic ocupado;
  logic aceita;
  logic aceita_ler;
  logic aceita_escrever;
  logic drena;

  assign Vazio = (Ocupacao == '0);
  assign Cheio = (Ocupacao == N_ENTRADAS);

  // Stall uses Cheio only, even if a drain would free a slot this cycle.
  assign pedido          = CpuLer | CpuEscrever;
  assign ocupado         = (estado == LEITURA) || (estado == DRENANDO);
  assign CpuEspera       = pedido & (ocupado | (CpuEscrever & Cheio));
  assign aceita          = pedido & ~CpuEspera;
  assign aceita_ler      = aceita & CpuLer;
  // A simultaneous load+store serves the load and drops the store.
  assign aceita_escrever = aceita & CpuEscrever & ~CpuLer;
  assign drena           = ~Vazio & (estado != LEITURA);

  always_comb begin
    MemLerMemoria      = (estado == LEITURA);
    MemEscreveMemoria  = drena;
    MemEndereco        = '0;
    MemDadoPraEscrever = '0;
    if (estado == LEITURA) begin
      MemEndereco = end_leitura;
    end else if (drena) begin
      MemEndereco        = fila_end[cabeca];
      MemDadoPraEscrever = fila_dado[cabeca];
    end
  end

`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
  logic       acerto;
  logic [7:0] dado_encaminhado;
  logic       enc_pendente;
  logic [7:0] enc_dado;

  // Scan from head to tail so the last match seen is the youngest store.
  // Uses pre-edge contents, so a head being drained this cycle still matches.
  always_comb begin
    acerto           = 1'b0;
    dado_encaminhado = '0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (((PW+1)'(i) < Ocupacao) && (fila_end[cabeca + PW'(i)] == CpuEndereco)) begin
        acerto           = 1'b1;
        dado_encaminhado = fila_dado[cabeca + PW'(i)];
      end
    end
  end
`else
  logic carga_pendente;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      cabeca      <= '0;
      cauda       <= '0;
      Ocupacao    <= '0;
      end_leitura <= '0;
      CpuPronto   <= 1'b0;
      CpuDadoLido <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        fila_end[i]  <= '0;
        fila_dado[i] <= '0;
      end
`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
      enc_pendente <= 1'b0;
      enc_dado     <= '0;
`else
      carga_pendente <= 1'b0;
`endif
    end else begin
      CpuPronto <= 1'b0;

      if (aceita_escrever) begin
        fila_end[cauda]  <= CpuEndereco;
        fila_dado[cauda] <= CpuDado;
        cauda            <= cauda + 1'b1;
      end
      if (drena) begin
        cabeca <= cabeca + 1'b1;
      end
      if (aceita_escrever && !drena) begin
        Ocupacao <= Ocupacao + 1'b1;
      end else if (!aceita_escrever && drena) begin
        Ocupacao <= Ocupacao - 1'b1;
      end

      case (estado)
        OCIOSO, CAPTURA: begin
          // Memory data read during LEITURA is valid throughout CAPTURA.
          if (estado == CAPTURA) begin
            CpuDadoLido <= MemDadoLido;
            CpuPronto   <= 1'b1;
          end
          if (aceita_ler) begin
            end_leitura <= CpuEndereco;
`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
            estado <= acerto ? OCIOSO : LEITURA;
`else
            if (Vazio) begin
              estado <= LEITURA;
            end else begin
              estado         <= DRENANDO;
              carga_pendente <= 1'b1;
            end
`endif
          end else if (Descarrega) begin
            estado <= DRENANDO;
          end else begin
            estado <= OCIOSO;
          end
        end
        LEITURA: estado <= CAPTURA;
        DRENANDO: begin
          if (Vazio) begin
`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
            estado <= OCIOSO;
`else
            estado         <= carga_pendente ? LEITURA : OCIOSO;
            carga_pendente <= 1'b0;
`endif
          end
        end
        default: estado <= OCIOSO;
      endcase

`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
      // Forwarded data is held one cycle so a hit completes one edge after accept.
      enc_pendente <= aceita_ler & acerto;
      if (aceita_ler && acerto) begin
        enc_dado <= dado_encaminhado;
      end
      if (enc_pendente) begin
        CpuDadoLido <= enc_dado;
        CpuPronto   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_buffer_escrita.sv
// tb/tb_buffer_escrita.sv - self-checking bench for buffer_escrita
module tb_buffer_escrita;

  localparam int PROF = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [7:0]              CpuEndereco = '0;
  logic [7:0]              CpuDado = '0;
  logic                    CpuLer = 1'b0;
  logic                    CpuEscrever = 1'b0;
  logic                    Descarrega = 1'b0;
  logic                    CpuEspera;
  logic                    CpuPronto;
  logic [7:0]              CpuDadoLido;
  logic [7:0]              MemEndereco;
  logic [7:0]              MemDadoPraEscrever;
  logic                    MemLerMemoria;
  logic                    MemEscreveMemoria;
  logic [7:0]              MemDadoLido = '0;
  logic                    Cheio;
  logic                    Vazio;
  logic [$clog2(PROF):0]   Ocupacao;

  buffer_escrita #(.PROFUNDIDADE(PROF)) dut (
    .clock(clock), .reset(reset),
    .CpuEndereco(CpuEndereco), .CpuDado(CpuDado),
    .CpuLer(CpuLer), .CpuEscrever(CpuEscrever), .Descarrega(Descarrega),
    .CpuEspera(CpuEspera), .CpuPronto(CpuPronto), .CpuDadoLido(CpuDadoLido),
    .MemEndereco(MemEndereco), .MemDadoPraEscrever(MemDadoPraEscrever),
    .MemLerMemoria(MemLerMemoria), .MemEscreveMemoria(MemEscreveMemoria),
    .MemDadoLido(MemDadoLido),
    .Cheio(Cheio), .Vazio(Vazio), .Ocupacao(Ocupacao)
  );

  always #5 clock = ~clock;

  // Data memory model: synchronous read on posedge, write on negedge.
  logic [7:0] mem [256];
  logic       mem_carga = 1'b1;
  int         n_escritas = 0;

  function automatic logic [7:0] init_val(input int a);
    return (a == 'h30) ? 8'h7E : (8'(a) ^ 8'h5A);
  endfunction

  always @(negedge clock) begin
    if (mem_carga) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      n_escritas <= 0;
    end else if (MemEscreveMemoria) begin
      mem[MemEndereco] <= MemDadoPraEscrever;
      n_escritas       <= n_escritas + 1;
    end
  end

  always @(posedge clock) begin
    if (MemLerMemoria) MemDadoLido <= mem[MemEndereco];
  end

  int total = 0;
  int bad   = 0;

  task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nome, got, exp);
    end
  endtask

  typedef struct {
    logic       ler, esc, desc;
    logic [7:0] ender, dado;
    logic       x_espera, x_re, x_we;
    logic [7:0] x_mend, x_mdado;
    logic       x_pronto;
    logic [7:0] x_lido;
    int         x_occ;
  } vetor_t;

  typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;
  typedef struct { int cyc; logic [7:0] d; } pronto_t;

  vetor_t     tab [24];
  ent_t       fila [$];
  pronto_t    pq [$];
  logic [7:0] dourado [256];

  task automatic linha(input int i, input logic l, e, d, input logic [7:0] en, dd,
                       input logic xe, xr, xw, input logic [7:0] xm, xd,
                       input logic xp, input logic [7:0] xl, input int xo);
    tab[i] = '{l, e, d, en, dd, xe, xr, xw, xm, xd, xp, xl, xo};
  endtask

  task automatic reinicia();
    reset = 1'b0; mem_carga = 1'b1;
    CpuLer = 0; CpuEscrever = 0; Descarrega = 0;
    repeat (2) @(negedge clock);
    mem_carga = 1'b0;
    #1 reset = 1'b1;
  endtask

  logic       p_ler, p_esc;
  logic [7:0] p_end, p_dado;
  int         cyc, espera_cnt, r, lat, k, ndiff, esc_antes;
  logic       hit, acc;

  initial begin
    //   l e d  addr   data  | esp re we mend   mdado  pr lido   occ
    linha( 0, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'h00, 0);
    linha( 1, 0,1,0, 8'h10, 8'hA0, 0,0,0, 8'h00, 8'h00, 0, 8'h00, 0);
    linha( 2, 0,1,0, 8'h11, 8'hA1, 0,0,1, 8'h10, 8'hA0, 0, 8'h00, 1);
    linha( 3, 0,0,0, 8'h00, 8'h00, 0,0,1, 8'h11, 8'hA1, 0, 8'h00, 1);
    linha( 4, 1,0,0, 8'h30, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'h00, 0);
    linha( 5, 0,1,0, 8'h12, 8'hA2, 1,1,0, 8'h30, 8'h00, 0, 8'h00, 0);
    linha( 6, 0,1,0, 8'h12, 8'hA2, 0,0,0, 8'h00, 8'h00, 0, 8'h00, 0);
    linha( 7, 0,0,0, 8'h00, 8'h00, 0,0,1, 8'h12, 8'hA2, 1, 8'h7E, 1);
    linha( 8, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'h7E, 0);
    linha( 9, 1,0,0, 8'h10, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'h7E, 0);
    linha(10, 0,0,0, 8'h00, 8'h00, 0,1,0, 8'h10, 8'h00, 0, 8'h7E, 0);
    linha(11, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'h7E, 0);
    linha(12, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 1, 8'hA0, 0);
    linha(13, 1,1,0, 8'h11, 8'hFF, 0,0,0, 8'h00, 8'h00, 0, 8'hA0, 0);
    linha(14, 0,0,0, 8'h00, 8'h00, 0,1,0, 8'h11, 8'h00, 0, 8'hA0, 0);
    linha(15, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'hA0, 0);
    linha(16, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 1, 8'hA1, 0);
    linha(17, 0,0,1, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'hA1, 0);
    linha(18, 1,0,0, 8'h12, 8'h00, 1,0,0, 8'h00, 8'h00, 0, 8'hA1, 0);
    linha(19, 1,0,0, 8'h12, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'hA1, 0);
    linha(20, 0,0,0, 8'h00, 8'h00, 0,1,0, 8'h12, 8'h00, 0, 8'hA1, 0);
    linha(21, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'hA1, 0);
    linha(22, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 1, 8'hA2, 0);
    linha(23, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0, 8'hA2, 0);

    reinicia();

    // Table: one row per cycle, inputs after posedge, outputs checked at negedge.
    for (int i = 0; i < 24; i++) begin
      @(posedge clock); #1;
      CpuLer = tab[i].ler; CpuEscrever = tab[i].esc; Descarrega = tab[i].desc;
      CpuEndereco = tab[i].ender; CpuDado = tab[i].dado;
      @(negedge clock);
      verifica($sformatf("t%0d_espera", i), CpuEspera, tab[i].x_espera);
      verifica($sformatf("t%0d_ler", i), MemLerMemoria, tab[i].x_re);
      verifica($sformatf("t%0d_esc", i), MemEscreveMemoria, tab[i].x_we);
      verifica($sformatf("t%0d_mend", i), MemEndereco, tab[i].x_mend);
      verifica($sformatf("t%0d_mdado", i), MemDadoPraEscrever, tab[i].x_mdado);
      verifica($sformatf("t%0d_pronto", i), CpuPronto, tab[i].x_pronto);
      verifica($sformatf("t%0d_lido", i), CpuDadoLido, tab[i].x_lido);
      verifica($sformatf("t%0d_occ", i), Ocupacao, tab[i].x_occ);
      verifica($sformatf("t%0d_vazio", i), Vazio, tab[i].x_occ == 0);
      verifica($sformatf("t%0d_cheio", i), Cheio, tab[i].x_occ == PROF);
    end

    // Two stores to one address, then a load that hits the head being drained.
    @(posedge clock); #1;
    CpuLer = 0; CpuEscrever = 1; Descarrega = 0; CpuEndereco = 8'h20; CpuDado = 8'h55;
    @(negedge clock);
    verifica("fw_st1_espera", CpuEspera, 0);
    @(posedge clock); #1;
    CpuDado = 8'h66;
    @(negedge clock);
    verifica("fw_st2_espera", CpuEspera, 0);
    verifica("fw_st2_drain", {MemEscreveMemoria, MemEndereco, MemDadoPraEscrever}, {1'b1, 8'h20, 8'h55});
    @(posedge clock); #1;
    CpuEscrever = 0; CpuLer = 1;
    @(negedge clock);
    verifica("fw_ld_espera", CpuEspera, 0);
    verifica("fw_ld_occ", Ocupacao, 1);
    verifica("fw_ld_drain", {MemEscreveMemoria, MemDadoPraEscrever}, {1'b1, 8'h66});
    lat = 0;
    for (k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      CpuLer = 0;
      @(negedge clock);
      if (CpuPronto) begin
        lat = k - 1;
        break;
      end
    end
`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
    verifica("fw_latencia", lat, 1);
`else
    verifica("fw_latencia", lat, 1 + 2);
`endif
    verifica("fw_dado", CpuDadoLido, 8'h66);

    // Asynchronous reset while a store is being drained.
    @(posedge clock); #1;
    CpuEscrever = 1; CpuEndereco = 8'h40; CpuDado = 8'h99;
    @(negedge clock);
    verifica("rst_st_espera", CpuEspera, 0);
    @(posedge clock); #1;
    CpuEscrever = 0;
    verifica("rst_pre_drain", MemEscreveMemoria, 1);
    esc_antes = n_escritas;
    reset = 1'b0;
    #1;
    verifica("rst_we", MemEscreveMemoria, 0);
    verifica("rst_mend", MemEndereco, 0);
    verifica("rst_occ", Ocupacao, 0);
    verifica("rst_vazio", Vazio, 1);
    verifica("rst_cheio", Cheio, 0);
    verifica("rst_pronto", CpuPronto, 0);
    verifica("rst_lido", CpuDadoLido, 0);
    @(negedge clock); #2;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    verifica("rst_sem_escrita", n_escritas, esc_antes);
    verifica("rst_mem40", mem['h40], init_val('h40));
    verifica("rst_occ_apos", Ocupacao, 0);

    // Randomized traffic against a transaction-level scoreboard.
    reinicia();
    for (int a = 0; a < 256; a++) dourado[a] = init_val(a);
    fila.delete(); pq.delete();
    p_ler = 0; p_esc = 0; p_end = 0; p_dado = 0;
    cyc = 0; espera_cnt = 0;
    for (int it = 0; it < 3000; it++) begin
      @(posedge clock); #1;
      Descarrega = 0;
      if (!p_ler && !p_esc && it < 2950) begin
        if ($urandom_range(0, 1) == 1) begin
          r      = $urandom_range(0, 9);
          p_ler  = (r <= 3) || (r == 9);
          p_esc  = (r >= 4);
          p_end  = 8'h80 + 8'($urandom_range(0, 7));
          p_dado = 8'($urandom);
          espera_cnt = 0;
        end else if ($urandom_range(0, 15) == 0) begin
          Descarrega = 1;
        end
      end
      CpuLer = p_ler; CpuEscrever = p_esc; CpuEndereco = p_end; CpuDado = p_dado;
      @(negedge clock);

      verifica("r_occ", Ocupacao, fila.size());
      verifica("r_vazio", Vazio, fila.size() == 0);
      verifica("r_cheio", Cheio, fila.size() == PROF);
      if (MemLerMemoria && MemEscreveMemoria) verifica("r_duas_en", 1, 0);
      if (!MemLerMemoria && !MemEscreveMemoria)
        verifica("r_mem_zero", {MemEndereco, MemDadoPraEscrever}, 0);
      if (!p_ler && !p_esc) verifica("r_espera_ocioso", CpuEspera, 0);

      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        verifica("r_pronto", CpuPronto, 1);
        verifica("r_lido", CpuDadoLido, pq[0].d);
        void'(pq.pop_front());
      end else begin
        verifica("r_pronto", CpuPronto, 0);
      end

      acc = (p_ler || p_esc) && !CpuEspera;
      if (acc && p_ler) begin
        hit = 0;
        foreach (fila[i]) if (fila[i].a == p_end) hit = 1;
`ifdef BUFFER_ESCRITA_ENCAMINHAMENTO_EN
        lat = hit ? 1 : 2;
`else
        lat = fila.size() + 2;
`endif
        pq.push_back('{cyc + 1 + lat, dourado[p_end]});
      end
      if (MemEscreveMemoria) begin
        if (fila.size() == 0) begin
          verifica("r_escrita_vazia", 1, 0);
        end else begin
          verifica("r_escrita", {MemEndereco, MemDadoPraEscrever}, {fila[0].a, fila[0].d});
          void'(fila.pop_front());
        end
      end
      if (acc && p_esc && !p_ler) begin
        dourado[p_end] = p_dado;
        fila.push_back('{p_end, p_dado});
      end
      if (acc) begin
        p_ler = 0; p_esc = 0;
      end else if (p_ler || p_esc) begin
        espera_cnt++;
        if (espera_cnt > 40) begin
          verifica("r_pedido_preso", espera_cnt, 0);
          p_ler = 0; p_esc = 0;
        end
      end
      cyc++;
    end

    @(negedge clock);
    verifica("fim_occ", Ocupacao, 0);
    verifica("fim_fila", fila.size(), 0);
    verifica("fim_pq", pq.size(), 0);
    ndiff = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== dourado[a]) ndiff++;
    verifica("fim_mem", ndiff, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
